// File: rtl/regfile_pkg.sv
// Shared constants and types for the multi-port register file and its scoreboard.
package regfile_pkg;
  localparam int XLEN_DEFAULT     = 32;
  localparam int NUM_REGS_DEFAULT = 32;
  localparam int REG_ZERO         = 0;
  localparam int REG_A0           = 10;

  typedef logic [4:0]  reg_addr_t;
  typedef logic [31:0] xlen_t;
endpackage

// File: rtl/regfile_multiport_if.sv
// Decode/write-back facing bundle of the register file: reads, issue, write-back, a0 tap.
interface regfile_multiport_if #(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32,
  parameter int NUM_RD   = 2
);
  localparam int AW = $clog2(NUM_REGS);

  logic [NUM_RD-1:0]            rd_en;
  logic [NUM_RD-1:0][AW-1:0]    rd_addr;
  logic [NUM_RD-1:0][XLEN-1:0]  rd_data;
  logic [NUM_RD-1:0]            rd_busy;
  logic                         stall;
  logic                         we;
  logic [AW-1:0]                wa;
  logic [XLEN-1:0]              wd;
  logic                         issue_valid;
  logic [AW-1:0]                issue_rd;
  logic [XLEN-1:0]              a0;

  modport master (
    output rd_en, rd_addr, we, wa, wd, issue_valid, issue_rd,
    input  rd_data, rd_busy, stall, a0
  );

  modport slave (
    input  rd_en, rd_addr, we, wa, wd, issue_valid, issue_rd,
    output rd_data, rd_busy, stall, a0
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: issue sets busy, write-back clears it, set wins on collision.
// Busy updates at the clock edge; per-port rd_busy is combinational and masked by a same-cycle write-back.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NUM_REGS = NUM_REGS_DEFAULT,
  parameter int NUM_RD   = 2,
  parameter int AW       = $clog2(NUM_REGS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      we,
  input  logic [AW-1:0]             wa,
  input  logic                      issue_valid,
  input  logic [AW-1:0]             issue_rd,
  input  logic [NUM_RD-1:0][AW-1:0] rd_addr,
  output logic [NUM_RD-1:0]         rd_busy
);
  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;

  always_comb begin
    busy_d = busy_q;
    if (we) busy_d[wa] = 1'b0;
    // A new producer supersedes the one retiring this cycle.
    if (issue_valid) busy_d[issue_rd] = 1'b1;
    busy_d[REG_ZERO] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  always_comb begin
    rd_busy = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      rd_busy[p] = busy_q[rd_addr[p]] & ~(we && (wa == rd_addr[p]));
    end
  end
endmodule

// File: rtl/regfile_multiport.sv
// N-read/1-write register file with x0 tied to zero, write-to-read bypass and pending-write stall.
// Reads and stall are combinational (0 cycles); writes and busy updates land at the clock edge.
module regfile_multiport
  import regfile_pkg::*;
#(
  parameter int XLEN     = XLEN_DEFAULT,
  parameter int NUM_REGS = NUM_REGS_DEFAULT,
  parameter int NUM_RD   = 2
) (
  input logic               clk,
  input logic               rst_n,
  regfile_multiport_if.slave bus
);
  localparam int AW = $clog2(NUM_REGS);

  logic [XLEN-1:0]   regs_q [NUM_REGS];
  logic [XLEN-1:0]   regs_d [NUM_REGS];
  logic [NUM_RD-1:0] rd_busy_w;

  always_comb begin
    regs_d = regs_q;
    if (bus.we && (bus.wa != AW'(REG_ZERO))) regs_d[bus.wa] = bus.wd;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  // Bypass is gated by reset so reads show zero for the whole reset window.
  always_comb begin
    bus.rd_data = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      if (bus.rd_addr[p] == AW'(REG_ZERO))
        bus.rd_data[p] = '0;
      else if (rst_n && bus.we && (bus.wa == bus.rd_addr[p]))
        bus.rd_data[p] = bus.wd;
      else
        bus.rd_data[p] = regs_q[bus.rd_addr[p]];
    end
  end

  regfile_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .NUM_RD   (NUM_RD),
    .AW       (AW)
  ) u_scoreboard (
    .clk         (clk),
    .rst_n       (rst_n),
    .we          (bus.we),
    .wa          (bus.wa),
    .issue_valid (bus.issue_valid),
    .issue_rd    (bus.issue_rd),
    .rd_addr     (bus.rd_addr),
    .rd_busy     (rd_busy_w)
  );

  assign bus.rd_busy = rd_busy_w;
  assign bus.stall   = |(bus.rd_en & rd_busy_w);
  assign bus.a0      = regs_q[REG_A0];
endmodule
